// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - 4-digit common-anode 7-segment scan controller
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the highest non-zero nibble)
module seven_segment_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  digit_nibble,
    output logic        dp,
    output logic [3:0]  anode,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } state_t;

    logic [CNT_W-1:0] div_cnt_q;
    logic [15:0]      shadow_val_q;
    logic [3:0]       shadow_dp_q;
    state_t           state_q;
    logic [1:0]       idx;
    logic             tick;
    logic             blank;
    logic [3:0]       digit_nibble_q;
    logic             dp_q;
    logic [3:0]       anode_q;
    logic             frame_done_q;

    assign idx  = state_q;
    assign tick = enable && (div_cnt_q == DIV_LAST);

`ifdef LEADING_ZERO_BLANK_EN
    logic [1:0] msd;

    // Highest non-zero nibble; digit 0 is the floor so a zero value still shows "0"
    always_comb begin
        msd = 2'd0;
        if (shadow_val_q[7:4]   != 4'h0) msd = 2'd1;
        if (shadow_val_q[11:8]  != 4'h0) msd = 2'd2;
        if (shadow_val_q[15:12] != 4'h0) msd = 2'd3;
        blank = (idx > msd);
    end
`else
    assign blank = 1'b0;
`endif

    // Shadow registers: load is accepted whether or not scanning is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
        end else if (load) begin
            shadow_val_q <= value;
            shadow_dp_q  <= dp_in;
        end
    end

    // Slot divider: held at zero while disabled so re-enable gives a full first slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else if (!enable || tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // Scan FSM with registered outputs; outputs reflect the state and shadows before this edge,
    // so a load coinciding with a tick shows up together with the new digit one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= DIG0;
            digit_nibble_q <= 4'h0;
            dp_q           <= 1'b0;
            anode_q        <= 4'hF;
            frame_done_q   <= 1'b0;
        end else begin
            if (!enable) begin
                state_q <= DIG0;
            end else if (tick) begin
                case (state_q)
                    DIG0:    state_q <= DIG1;
                    DIG1:    state_q <= DIG2;
                    DIG2:    state_q <= DIG3;
                    DIG3:    state_q <= DIG0;
                    default: state_q <= DIG0;
                endcase
            end
            frame_done_q <= tick && (state_q == DIG3);
            if (enable) begin
                digit_nibble_q <= shadow_val_q[{idx, 2'b00} +: 4];
                dp_q           <= blank ? 1'b0 : shadow_dp_q[idx];
                anode_q        <= blank ? 4'hF : ~(4'b0001 << idx);
            end else begin
                digit_nibble_q <= shadow_val_q[3:0];
                dp_q           <= 1'b0;
                anode_q        <= 4'hF;
            end
        end
    end

    assign digit_nibble = digit_nibble_q;
    assign dp           = dp_q;
    assign anode        = anode_q;
    assign frame_done   = frame_done_q;

endmodule
